iter_shifter: RTL

- Multi-cycle shift unit for the datapath. It applies the single-bit shift operations (pass, LSL, LSR, ASR) repeatedly, up to 15 positions, one bit per clock.
- Uses a start/busy/done handshake so the controller FSM can issue multi-bit shifts without a combinational barrel shifter.
- Reports the last bit shifted out on a carry output for status flags.

---
 rtl/iter_shifter.sv | 111 +++++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shift unit: one bit per clock, start/busy/done handshake, carry out.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

  state_t           state;
  state_t           state_next;
  logic [1:0]       op;
  logic [AMT_W-1:0] count;
  logic             accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start is taken in IDLE or DONE; DONE-with-start chains straight into the next shift.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sout  <= '0;
      carry <= 1'b0;
      op    <= OP_PASS;
      count <= '0;
    end else if (accept) begin
      sout  <= in;
      carry <= 1'b0;
      op    <= shift;
      count <= (shift == OP_PASS) ? '0 : amt;
    end else if (state == SHIFT && count != '0) begin
      count <= count - 1'b1;
      case (op)
        OP_LSL: begin
          sout  <= {sout[WIDTH-2:0], 1'b0};
          carry <= sout[WIDTH-1];
        end
        OP_LSR: begin
          sout  <= {1'b0, sout[WIDTH-1:1]};
          carry <= sout[0];
        end
        OP_ASR: begin
          sout  <= {sout[WIDTH-1], sout[WIDTH-1:1]};
          carry <= sout[0];
        end
        default: begin
          sout  <= sout;
          carry <= carry;
        end
      endcase
    end
  end

endmodule
